// File: rtl/regfile_mp.sv
// Multi-port register file with a soft-clear sweep; define REGFILE_MP_BYPASS_EN for write-through reads.
// Reads are combinational and forced to 0 while busy; writes land on the next edge; no backpressure.
module regfile_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int DBG_REG       = 10
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_clr_req,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    o_rd_data,
    input  logic                              i_we,
    input  logic [ADDRESS_WIDTH-1:0]          i_wa,
    input  logic [DATA_WIDTH-1:0]             i_wd,
    output logic [DATA_WIDTH-1:0]             o_dbg_data,
    output logic                              o_busy
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH-1);
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DBG_REG);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state;
    logic [ADDRESS_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0]   r_regs [DEPTH];

    logic w_idle;
    logic w_wr_en;

    // Reset is folded in so outputs read as "sweeping" even before the first edge.
    assign w_idle  = i_rst_n && (r_state == S_IDLE);
    assign w_wr_en = w_idle && i_we && (i_wa != '0) && !i_clr_req;
    assign o_busy  = !w_idle;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_CLEAR;
            r_idx   <= ADDRESS_WIDTH'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= S_CLEAR;
                        r_idx   <= ADDRESS_WIDTH'(1);
                    end
                end
                S_CLEAR: begin
                    r_idx <= r_idx + ADDRESS_WIDTH'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register 0 is never written; the read path masks it instead.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && (r_state == S_CLEAR)) begin
            r_regs[r_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_val(
        input logic                     idle,
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic                     hit,
        input logic [DATA_WIDTH-1:0]    wd,
        input logic [DATA_WIDTH-1:0]    stored
    );
        if (!idle || (addr == '0)) return '0;
        if (hit) return wd;
        return stored;
    endfunction

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_addr;
        logic                     w_hit;
        assign w_addr = i_rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_MP_BYPASS_EN
        assign w_hit = w_wr_en && (w_addr == i_wa);
`else
        assign w_hit = 1'b0;
`endif
        assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = read_val(w_idle, w_addr, w_hit, i_wd, r_regs[w_addr]);
    end

    logic w_dbg_hit;
`ifdef REGFILE_MP_BYPASS_EN
    assign w_dbg_hit = w_wr_en && (DBG_IDX == i_wa);
`else
    assign w_dbg_hit = 1'b0;
`endif
    assign o_dbg_data = read_val(w_idle, DBG_IDX, w_dbg_hit, i_wd, r_regs[DBG_IDX]);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp with a behavioural model of the register file and sweep.
module tb_regfile_mp;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int DBG = 10;
    localparam int SWEEP = (2**AW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_req;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [DW-1:0]     dbg_data;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m [2**AW];
    int            left;

    regfile_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .DBG_REG(DBG)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .i_we(we), .i_wa(wa), .i_wd(wd),
        .o_dbg_data(dbg_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (!rst_n || left > 0 || a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (we && wa != 0 && !clr_req && int'(wa) == a) return wd;
`endif
        return m[a];
    endfunction

    function automatic void model_edge();
        if (!rst_n || (left == 0 && clr_req)) begin
            left = SWEEP;
            for (int i = 0; i < 2**AW; i++) m[i] = '0;
        end else if (left > 0) begin
            left--;
        end else if (we && wa != 0) begin
            m[wa] = wd;
        end
    endfunction

    task automatic set_in(input logic r, input logic c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NR*AW-1:0] ra);
        rst_n = r; clr_req = c; we = w; wa = a; wd = d; rd_addr = ra;
        #1;
    endtask

    task automatic rnd_in(input logic r, input int clr_odds);
        set_in(r, $urandom_range(0, clr_odds) == 0, 1'($urandom), AW'($urandom), $urandom, (NR*AW)'($urandom));
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic step();
        for (int p = 0; p < NR; p++)
            chk($sformatf("rd%0d", p), rd_data[p*DW +: DW], exp_rd(int'(rd_addr[p*AW +: AW])));
        chk("dbg", dbg_data, exp_rd(DBG));
        chk("busy", {31'b0, busy}, {31'b0, (!rst_n || left > 0)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic count_sweep(input string name, input logic hold_we);
        int n = 0;
        while (busy && n < 100) begin
            if (hold_we) set_in(1'b1, 1'b1, 1'b1, 5'd3, 32'h55, {5'd3, 5'd10});
            else rnd_in(1'b1, 4);
            step();
            n++;
        end
        chk(name, n, SWEEP);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) m[i] = '0;
        left = SWEEP;

        set_in(1'b0, 1'b0, 1'b1, 5'd7, 32'hAAAA, {5'd7, 5'd10});
        chk("rst_busy_lit", {31'b0, busy}, 32'd1);
        chk("rst_rd_lit", rd_data[DW-1:0], 32'd0);
        step();
        set_in(1'b0, 1'b1, 1'b1, 5'd7, 32'hAAAA, {5'd7, 5'd10});
        step();
        count_sweep("rst_sweep_len", 1'b0);

        for (int a = 0; a < 2**AW; a++) begin
            set_in(1'b1, 1'b0, 1'b0, '0, '0, {AW'(a), AW'(a)});
            chk("post_rst_zero", rd_data[DW-1:0], 32'd0);
            step();
        end

        set_in(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, {5'd0, 5'd0});
        step();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, {5'd5, 5'd5});
        chk("wr5_p0", rd_data[DW-1:0], 32'hDEADBEEF);
        chk("wr5_p1", rd_data[2*DW-1:DW], 32'hDEADBEEF);
        step();

        set_in(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, {5'd0, 5'd0});
        step();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, {5'd0, 5'd0});
        chk("reg0_zero", rd_data[DW-1:0], 32'd0);
        step();

        set_in(1'b1, 1'b0, 1'b1, 5'd10, 32'h77, {5'd0, 5'd0});
        step();
        set_in(1'b1, 1'b0, 1'b1, 5'd10, 32'h1234, {5'd0, 5'd10});
`ifdef REGFILE_MP_BYPASS_EN
        chk("byp_rd0", rd_data[DW-1:0], 32'h1234);
        chk("byp_dbg", dbg_data, 32'h1234);
`else
        chk("byp_rd0", rd_data[DW-1:0], 32'h77);
        chk("byp_dbg", dbg_data, 32'h77);
`endif
        step();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, {5'd10, 5'd10});
        chk("wr10_next", rd_data[DW-1:0], 32'h1234);
        chk("dbg_next", dbg_data, 32'h1234);
        step();

        for (int a = 1; a < 2**AW; a++) begin
            set_in(1'b1, 1'b0, 1'b1, AW'(a), DW'(a), {AW'(a), 5'd3});
            step();
        end
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, {5'd31, 5'd3});
        chk("fill3", rd_data[DW-1:0], 32'd3);
        chk("fill31", rd_data[2*DW-1:DW], 32'd31);
        step();
        set_in(1'b1, 1'b1, 1'b1, 5'd3, 32'h55, {5'd3, 5'd3});
        step();
        count_sweep("clr_sweep_len", 1'b1);
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, {5'd10, 5'd3});
        chk("clr_reg3", rd_data[DW-1:0], 32'd0);
        chk("clr_dbg", dbg_data, 32'd0);
        step();

        set_in(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, {5'd0, 5'd0});
        step();
        for (int k = 0; k < 14; k++) begin
            rnd_in(1'b1, 1);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, {5'd0, 5'd0});
        step();
        count_sweep("restart_sweep_len", 1'b0);

        for (int k = 0; k < 2000; k++) begin
            rnd_in($urandom_range(0, 499) != 0, 63);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5: register index width; depth = 2**ADDRESS_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32: register width in bits.
REQ-003 Parameter NUM_READ, default 2, legal 1..4: number of independent read ports.
REQ-004 Parameter DBG_REG, default 10: index of the register mirrored on dbg_data (a0).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 clr_req  in  1  request a soft clear of the whole file.
REQ-008 rd_addr  in  NUM_READ*ADDRESS_WIDTH  packed read addresses; port i occupies slice i.
REQ-009 rd_data  out  NUM_READ*DATA_WIDTH  packed read data; port i occupies slice i.
REQ-010 we  in  1  write enable.
REQ-011 wa  in  ADDRESS_WIDTH  write address.
REQ-012 wd  in  DATA_WIDTH  write data.
REQ-013 dbg_data  out  DATA_WIDTH  current contents of register DBG_REG.
REQ-014 busy  out  1  high while a clear sweep is in progress.

Function
REQ-015 Register 0 SHALL read as zero at all times; writes to address 0 SHALL be discarded.
REQ-016 The FSM SHALL have two states: IDLE and CLEAR.
REQ-017 In IDLE, when we=1 and wa!=0, reg[wa] SHALL take wd at the rising edge.
REQ-018 Reads in IDLE SHALL be combinational: rd_data slice i = reg[rd_addr slice i], with no clock latency.
REQ-019 In IDLE, clr_req=1 at a rising edge SHALL move the FSM to CLEAR and set the sweep index to 1; any write in that same cycle SHALL be discarded.
REQ-020 In CLEAR, each rising edge SHALL write 0 to reg[idx] and increment idx.
REQ-021 When idx = 2**ADDRESS_WIDTH-1 is cleared, the FSM SHALL return to IDLE on that same edge, so a sweep lasts exactly 2**ADDRESS_WIDTH-1 cycles.
REQ-022 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-023 In CLEAR, all rd_data slices and dbg_data SHALL read 0.
REQ-024 In CLEAR, we SHALL be ignored.
REQ-025 In CLEAR, clr_req SHALL be ignored; the sweep does not restart.
REQ-026 dbg_data SHALL equal reg[DBG_REG] under the same bypass rule as the read ports.
REQ-027 Several read ports addressing the same register SHALL all return the identical value.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force the FSM to CLEAR and set idx to 1, including when a sweep is already in progress (the sweep restarts).
REQ-029 While rst_n=0 and on release, outputs SHALL be: busy=1, rd_data=0, dbg_data=0.
REQ-030 After rst_n rises, busy SHALL fall 2**ADDRESS_WIDTH-1 edges later (31 edges for the default parameters).
REQ-031 After busy falls, every register SHALL read 0.

Configuration
REQ-032 Macro REGFILE_MP_BYPASS_EN defined: in IDLE, when we=1, wa!=0 and a read address equals wa, that port (and dbg_data, when DBG_REG=wa) SHALL return wd in the same cycle (write-through).
REQ-033 Macro REGFILE_MP_BYPASS_EN undefined: reads SHALL return the pre-edge register value; the new value is visible from the next cycle.

Verification
REQ-034 Reset, then count edges: busy=1 for exactly 31 edges after rst_n rises; afterwards all 32 registers read 0.
REQ-035 In IDLE, write wa=5, wd=0xDEADBEEF, then read port 0 at 5 and port 1 at 5 the next cycle: both read 0xDEADBEEF.
REQ-036 Write wa=0, wd=0xFFFFFFFF, then read address 0: rd_data=0.
REQ-037 Write wa=10, wd=0x1234, with rd_addr0=10 in the same cycle: with BYPASS_EN, rd_data0=0x1234 that cycle; without it, the old value, then 0x1234 the next cycle; dbg_data follows the same rule.
REQ-038 Fill registers 1..31 with their own index, pulse clr_req, and hold we=1 (wa=3, wd=0x55) during the sweep: busy=1 for 31 edges, reads return 0, and afterwards reg[3]=0.
REQ-039 Assert rst_n=0 for one edge at sweep index 15: the sweep restarts at 1 and busy stays high for a further 31 edges.
